// File: rtl/max_k_pkg.sv
// Shared types and helpers for the sequential group-maximum block.
package max_k_pkg;

    // Two-state group FSM: collect K operands, then present the result.
    typedef enum logic {
        ACCEPT = 1'b0,
        EMIT   = 1'b1
    } state_e;

    // Index width: clog2(K), but never narrower than one bit (K=1 still needs a port).
    function automatic int unsigned idx_width(input int unsigned k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/max_gt_cmp.sv
// Combinational strict greater-than, natural or two's-complement.
module max_gt_cmp #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         is_signed,
    output logic         gt
);

    logic [N-1:0] xa;
    logic [N-1:0] ya;
    logic [N:0]   sum;

    // Flipping the MSB maps two's-complement order onto unsigned order; then
    // x + ~y + 1 carries out exactly when x >= y, and equality is excluded.
    always_comb begin
        xa        = x;
        ya        = y;
        xa[N-1]   = x[N-1] ^ is_signed;
        ya[N-1]   = y[N-1] ^ is_signed;
        sum       = {1'b0, xa} + {1'b0, ~ya} + {{N{1'b0}}, 1'b1};
        gt        = sum[N] & (xa != ya);
    end

endmodule

// File: rtl/max_k_seq.sv
// Accepts K operands per group over valid/ready, emits the group maximum and
// the 0-based position of its earliest occurrence.
module max_k_seq
    import max_k_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned K     = 3,
    parameter int unsigned IDX_W = idx_width(K)
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_max,
    output logic [IDX_W-1:0] out_idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d;
    logic             gt;

    max_gt_cmp #(
        .N(N)
    ) u_cmp (
        .x         (in_data),
        .y         (max_q),
        .is_signed (mode_q),
        .gt        (gt)
    );

    // Next-state: running max while accepting, hold result until consumed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        unique case (state_q)
            ACCEPT: begin
                if (in_valid) begin
                    if (cnt_q == '0) begin
                        max_d  = in_data;
                        idx_d  = '0;
                        mode_d = in_signed;
                    end else if (gt) begin
                        // Strict compare: ties keep the earlier index.
                        max_d = in_data;
                        idx_d = cnt_q;
                    end
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = EMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= ACCEPT;
            cnt_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    // Outputs are state decodes and registered values only.
    always_comb begin
        in_ready  = (state_q == ACCEPT);
        out_valid = (state_q == EMIT);
        out_max   = max_q;
        out_idx   = idx_q;
    end

endmodule

// File: tb/tb_max_k_seq.sv
// Self-checking bench for max_k_seq: directed table, corner sequences and
// randomized groups against a value-level reference model.
module tb_max_k_seq;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_;
    logic       in_valid, in_signed, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [7:0] out_max;
    logic [1:0] out_idx;

    logic       b_valid, b_signed, b_out_ready;
    logic [3:0] b_data;
    logic       b_in_ready, b_out_valid;
    logic [3:0] b_max;
    logic [0:0] b_idx;

    max_k_seq #(.N(8), .K(3)) dut (
        .clock     (clock),
        .reset_    (reset_),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx)
    );

    max_k_seq #(.N(4), .K(1)) dut_k1 (
        .clock     (clock),
        .reset_    (reset_),
        .in_valid  (b_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_data),
        .in_signed (b_signed),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_max   (b_max),
        .out_idx   (b_idx)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: timeout waiting for handshake, got none expected one", name);
    endtask

    // Offer one operand and return #1 after the edge that transfers it.
    task automatic push(input logic [7:0] d, input logic s);
        int n = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) timeout_fail("push");
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Wait for a result, compare it, consume it.
    task automatic pull(input string name, input logic [7:0] emax, input logic [1:0] eidx);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) timeout_fail({name, "_pull"});
        check({name, "_max"}, out_max, emax);
        check({name, "_idx"}, out_idx, eidx);
        @(posedge clock); #1;
        out_ready = 1'b0;
        check({name, "_ready_after"}, in_ready, 1'b1);
    endtask

    // Reference: interpret operands as integers in the latched mode, take the
    // first strictly largest.
    function automatic void model(input logic [7:0] d0, input logic [7:0] d1,
                                  input logic [7:0] d2, input logic s,
                                  output logic [7:0] m, output logic [1:0] idx);
        logic [7:0] d[3];
        int v[3];
        int best;
        d = '{d0, d1, d2};
        for (int i = 0; i < 3; i++) v[i] = s ? int'($signed(d[i])) : int'(d[i]);
        best = v[0];
        idx  = 2'd0;
        for (int i = 1; i < 3; i++) begin
            if (v[i] > best) begin
                best = v[i];
                idx  = 2'(i);
            end
        end
        m = d[idx];
    endfunction

    typedef struct {
        logic [7:0] d0, d1, d2;
        logic       s0, s1, s2;
        logic [7:0] emax;
        logic [1:0] eidx;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{8'd12,  8'd200, 8'd7,   1'b0, 1'b0, 1'b0, 8'd200, 2'd1};
        vecs[1] = '{8'h80,  8'hFF,  8'h7F,  1'b1, 1'b1, 1'b1, 8'h7F,  2'd2};
        vecs[2] = '{8'h80,  8'hFF,  8'h7F,  1'b0, 1'b0, 1'b0, 8'hFF,  2'd1};
        vecs[3] = '{8'd5,   8'd5,   8'd5,   1'b1, 1'b0, 1'b0, 8'd5,   2'd0};
        vecs[4] = '{8'hFF,  8'h01,  8'h00,  1'b0, 1'b1, 1'b1, 8'hFF,  2'd0};
        vecs[5] = '{8'h00,  8'hFF,  8'hFF,  1'b0, 1'b0, 1'b0, 8'hFF,  2'd1};
        vecs[6] = '{8'h7F,  8'h80,  8'h7F,  1'b1, 1'b1, 1'b1, 8'h7F,  2'd0};
        vecs[7] = '{8'h80,  8'h80,  8'h80,  1'b1, 1'b1, 1'b1, 8'h80,  2'd0};
        vecs[8] = '{8'h01,  8'hFF,  8'h00,  1'b1, 1'b0, 1'b0, 8'h01,  2'd0};

        reset_      = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_signed   = 1'b0;
        out_ready   = 1'b0;
        b_valid     = 1'b0;
        b_data      = '0;
        b_signed    = 1'b0;
        b_out_ready = 1'b0;
        #1;
        check("reset_in_ready",  in_ready,  1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_max",   out_max,   8'h00);
        check("reset_out_idx",   out_idx,   2'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_ = 1'b1;
        @(posedge clock); #1;

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            push(vecs[i].d0, vecs[i].s0);
            push(vecs[i].d1, vecs[i].s1);
            push(vecs[i].d2, vecs[i].s2);
            check($sformatf("vec%0d_latency_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d_emit_not_ready", i), in_ready, 1'b0);
            pull($sformatf("vec%0d", i), vecs[i].emax, vecs[i].eidx);
        end

        // Back-pressure: result held, pending input ignored.
        push(8'd3, 1'b0);
        push(8'd1, 1'b0);
        push(8'd2, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h44;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            check($sformatf("bp%0d_valid", c), out_valid, 1'b1);
            check($sformatf("bp%0d_max", c), out_max, 8'd3);
            check($sformatf("bp%0d_idx", c), out_idx, 2'd0);
            check($sformatf("bp%0d_in_ready", c), in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_ready", in_ready, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        push(8'd10, 1'b0);
        push(8'd20, 1'b0);
        push(8'd30, 1'b0);
        pull("after_bp", 8'd30, 2'd2);

        // Mid-group asynchronous reset discards the partial group.
        push(8'd9, 1'b0);
        push(8'd250, 1'b0);
        #2 reset_ = 1'b0;
        #1;
        check("midrst_in_ready",  in_ready,  1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_max",   out_max,   8'h00);
        #2 reset_ = 1'b1;
        @(posedge clock); #1;
        push(8'd1, 1'b0);
        push(8'd2, 1'b0);
        push(8'd3, 1'b0);
        pull("after_rst", 8'd3, 2'd2);

        // K=1, N=4: each operand is its own group, period two cycles.
        b_out_ready = 1'b1;
        b_valid     = 1'b1;
        b_data      = 4'hA;
        check("k1_ready0", b_in_ready, 1'b1);
        @(posedge clock); #1;
        check("k1_a_valid", b_out_valid, 1'b1);
        check("k1_a_max",   b_max, 4'hA);
        check("k1_a_idx",   b_idx, 1'b0);
        check("k1_a_busy",  b_in_ready, 1'b0);
        b_data = 4'h3;
        @(posedge clock); #1;
        check("k1_gap_valid", b_out_valid, 1'b0);
        check("k1_gap_ready", b_in_ready, 1'b1);
        @(posedge clock); #1;
        check("k1_b_valid", b_out_valid, 1'b1);
        check("k1_b_max",   b_max, 4'h3);
        check("k1_b_idx",   b_idx, 1'b0);
        b_valid = 1'b0;
        @(posedge clock); #1;
        check("k1_done_valid", b_out_valid, 1'b0);
        b_out_ready = 1'b0;

        // Randomized groups with idle gaps and output stalls.
        for (int g = 0; g < 60; g++) begin
            logic [7:0] d[3];
            logic       s[3];
            logic [7:0] emax;
            logic [1:0] eidx;
            for (int i = 0; i < 3; i++) begin
                case ($urandom_range(0, 4))
                    0:       d[i] = 8'h00;
                    1:       d[i] = 8'hFF;
                    2:       d[i] = 8'h80;
                    3:       d[i] = 8'h7F;
                    default: d[i] = 8'($urandom);
                endcase
                s[i] = 1'($urandom);
            end
            model(d[0], d[1], d[2], s[0], emax, eidx);
            for (int i = 0; i < 3; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clock); #1;
                end
                push(d[i], s[i]);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock); #1;
            end
            pull($sformatf("rand%0d", g), emax, eidx);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
